// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller and the
// core writeback path (load extension).
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_ERR     = 3'd4
  } state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  localparam int unsigned NUM_LANES = 4;

  // Lane k carries the byte at (address + k).
  typedef logic [7:0] byte_lane_t [0:NUM_LANES-1];

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// RISC-V load extension: selects byte/half/word from the lanes and sign- or
// zero-extends by funct3. Unknown funct3 yields zero.
module mem_load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  byte_lane_t  lanes_i,
  output logic [31:0] data_o
);

  always_comb begin
    data_o = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{lanes_i[0][7]}}, lanes_i[0]};
      F3_H:    data_o = {{16{lanes_i[1][7]}}, lanes_i[1], lanes_i[0]};
      F3_W:    data_o = {lanes_i[3], lanes_i[2], lanes_i[1], lanes_i[0]};
      F3_BU:   data_o = {24'h0, lanes_i[0]};
      F3_HU:   data_o = {16'h0, lanes_i[1], lanes_i[0]};
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Shares the byte-lane data memory between instruction fetch and load/store,
// with round-robin arbitration and read-modify-write for SB/SH.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned FETCH_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  output logic [31:0]       if_rdata,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_we,
  input  logic [2:0]        d_funct3,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_resp_valid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  output byte_lane_t        mem_data_in,
  input  byte_lane_t        mem_data_out
);

  state_e            state_q, state_d;
  logic              last_fetch_q, last_fetch_d;
  logic              is_fetch_q, is_fetch_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [15:0]       sdata_q, sdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              if_resp_q, if_resp_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic              d_resp_q, d_resp_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              d_err_q, d_err_d;

  logic              grant_if;
  logic [31:0]       ext_data;
  logic [31:0]       rd_word;

  // On a tie the requester that did not win last time is granted.
  assign grant_if     = if_req_valid && (!d_req_valid || !last_fetch_q);
  assign if_req_ready = rst_b && (state_q == ST_IDLE) && grant_if;
  assign d_req_ready  = rst_b && (state_q == ST_IDLE) && d_req_valid && !grant_if;

  mem_load_ext u_load_ext (
    .funct3_i (funct3_q),
    .lanes_i  (mem_data_out),
    .data_o   (ext_data)
  );

  always_comb begin
    rd_word = '0;
    for (int unsigned k = 0; k < NUM_LANES; k++) begin
      rd_word[8*k +: 8]  = mem_data_out[k];
      mem_data_in[k]     = mem_wdata_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    last_fetch_d = last_fetch_q;
    is_fetch_d   = is_fetch_q;
    store_d      = store_q;
    funct3_d     = funct3_q;
    sdata_d      = sdata_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    if_resp_d    = 1'b0;
    if_rdata_d   = '0;
    d_resp_d     = 1'b0;
    d_rdata_d    = '0;
    d_err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (if_req_ready) begin
          state_d      = ST_RD_ADDR;
          last_fetch_d = 1'b1;
          is_fetch_d   = 1'b1;
          store_d      = 1'b0;
          funct3_d     = F3_W;
          mem_addr_d   = if_addr;
        end else if (d_req_ready) begin
          last_fetch_d = 1'b0;
          is_fetch_d   = 1'b0;
          store_d      = d_we;
          funct3_d     = d_funct3;
          sdata_d      = d_wdata[15:0];
          // Illegal requests never touch the memory address or strobe.
          if (!f3_legal(d_we, d_funct3)) begin
            state_d = ST_ERR;
          end else begin
            mem_addr_d = d_addr;
            if (d_we && (d_funct3 == F3_W)) begin
              state_d     = ST_WR;
              mem_we_d    = 1'b1;
              mem_wdata_d = d_wdata;
            end else begin
              state_d = ST_RD_ADDR;
            end
          end
        end
      end
      ST_RD_ADDR: state_d = ST_RD_DATA;
      ST_RD_DATA: begin
        state_d = ST_IDLE;
        if (store_q) begin
          // Sub-word store: keep the upper lanes just read, replace the low ones.
          mem_wdata_d = {rd_word[31:16],
                         (funct3_q == F3_H) ? sdata_q[15:8] : rd_word[15:8],
                         sdata_q[7:0]};
          mem_we_d    = 1'b1;
          state_d     = ST_WR;
        end else if (is_fetch_q) begin
          if_resp_d  = 1'b1;
          if_rdata_d = ext_data;
        end else begin
          d_resp_d  = 1'b1;
          d_rdata_d = ext_data;
        end
      end
      ST_WR: begin
        d_resp_d = 1'b1;
        state_d  = ST_IDLE;
      end
      ST_ERR: begin
        d_resp_d = 1'b1;
        d_err_d  = 1'b1;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every register, including the write strobe, clears asynchronously so a
  // store in flight at reset is abandoned without a response.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= ST_IDLE;
      last_fetch_q <= (FETCH_FIRST == 0);
      is_fetch_q   <= 1'b0;
      store_q      <= 1'b0;
      funct3_q     <= '0;
      sdata_q      <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      if_resp_q    <= 1'b0;
      if_rdata_q   <= '0;
      d_resp_q     <= 1'b0;
      d_rdata_q    <= '0;
      d_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_fetch_q <= last_fetch_d;
      is_fetch_q   <= is_fetch_d;
      store_q      <= store_d;
      funct3_q     <= funct3_d;
      sdata_q      <= sdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      if_resp_q    <= if_resp_d;
      if_rdata_q   <= if_rdata_d;
      d_resp_q     <= d_resp_d;
      d_rdata_q    <= d_rdata_d;
      d_err_q      <= d_err_d;
    end
  end

  assign mem_addr      = mem_addr_q;
  assign mem_write_en  = mem_we_q;
  assign if_resp_valid = if_resp_q;
  assign if_rdata      = if_rdata_q;
  assign d_resp_valid  = d_resp_q;
  assign d_rdata       = d_rdata_q;
  assign d_err         = d_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: byte-lane memory model, response
// scoreboard with expected arrival cycle, write-strobe log.
module tb_mem_access_ctrl;
  import mem_ctrl_pkg::*;

  typedef struct {
    logic        is_fetch;
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req_valid, d_req_ready, d_we, d_resp_valid, d_err;
  logic [2:0]  d_funct3;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [31:0] mem_addr;
  logic        mem_write_en;
  byte_lane_t  mem_data_in, mem_data_out;

  logic [7:0]  mem [0:255];
  logic        mem_load;
  int unsigned cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  exp_t        sb[$];
  int unsigned we_log[$];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .FETCH_FIRST(0)) dut (
    .clk           (clk),
    .rst_b         (rst_b),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_addr       (if_addr),
    .if_resp_valid (if_resp_valid),
    .if_rdata      (if_rdata),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_we          (d_we),
    .d_funct3      (d_funct3),
    .d_addr        (d_addr),
    .d_wdata       (d_wdata),
    .d_resp_valid  (d_resp_valid),
    .d_rdata       (d_rdata),
    .d_err         (d_err),
    .mem_addr      (mem_addr),
    .mem_write_en  (mem_write_en),
    .mem_data_in   (mem_data_in),
    .mem_data_out  (mem_data_out)
  );

  function automatic logic [7:0] init_byte(input int unsigned a);
    case (a)
      32'h40: return 8'h80;
      32'h41: return 8'h7F;
      32'h42: return 8'h11;
      32'h43: return 8'h22;
      32'h44: return 8'h34;
      32'h45: return 8'h96;
      32'h50, 32'h51, 32'h52, 32'h53: return 8'h00;
      default: return 8'(a * 7 + 3);
    endcase
  endfunction

  function automatic logic [31:0] init_word(input int unsigned a);
    return {init_byte(a + 3), init_byte(a + 2), init_byte(a + 1), init_byte(a)};
  endfunction

  function automatic logic [31:0] mem_word(input int unsigned a);
    return {mem[8'(a + 3)], mem[8'(a + 2)], mem[8'(a + 1)], mem[8'(a)]};
  endfunction

  // Synchronous-read, write-at-edge memory; read returns pre-write data.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_load) begin
      for (int unsigned i = 0; i < 256; i++) mem[8'(i)] <= init_byte(i);
    end else if (mem_write_en) begin
      for (int unsigned k = 0; k < 4; k++) mem[8'(mem_addr + k)] <= mem_data_in[k];
    end
    for (int unsigned j = 0; j < 4; j++) mem_data_out[j] <= mem[8'(mem_addr + j)];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_b && mem_write_en) we_log.push_back(cyc);
    if (rst_b && (if_resp_valid || d_resp_valid)) begin
      chk("resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("resp_port", 32'({if_resp_valid, d_resp_valid}), e.is_fetch ? 32'd2 : 32'd1);
        chk("resp_cycle", cyc, e.cyc);
        if (e.is_fetch) begin
          chk("if_rdata", if_rdata, e.rdata);
        end else begin
          chk("d_rdata", d_rdata, e.rdata);
          chk("d_err", 32'(d_err), 32'(e.err));
        end
      end
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_ctl"}, 32'({mem_write_en, if_resp_valid, d_resp_valid, d_err,
                            if_req_ready, d_req_ready}), 32'h0);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
    chk({tag, "_wbytes"}, {mem_data_in[3], mem_data_in[2], mem_data_in[1], mem_data_in[0]}, 32'h0);
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  // Returns #1 after the accepting edge (first cycle of the transaction).
  task automatic data_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int unsigned lat, input logic push,
                          output int unsigned t_acc);
    exp_t e;
    int unsigned n = 0;
    @(negedge clk);
    d_we = we; d_funct3 = f3; d_addr = addr; d_wdata = wdata; d_req_valid = 1'b1;
    #1;
    while (!d_req_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("d_accept", 32'(d_req_ready), 32'd1);
    t_acc = cyc;
    if (push && d_req_ready) begin
      e.is_fetch = 1'b0; e.rdata = exp_rdata; e.err = exp_err; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp_rdata);
    int unsigned t;
    data_req(1'b0, f3, addr, 32'h0, exp_rdata, 1'b0, 3, 1'b1, t);
    wait_drain();
  endtask

  task automatic fetch_req(input logic [31:0] addr);
    exp_t e;
    int unsigned n = 0;
    @(negedge clk);
    if_addr = addr; if_req_valid = 1'b1;
    #1;
    while (!if_req_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("if_accept", 32'(if_req_ready), 32'd1);
    if (if_req_ready) begin
      e.is_fetch = 1'b1; e.rdata = init_word(addr); e.err = 1'b0; e.cyc = cyc + 3;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    chk("if_mem_addr", mem_addr, addr);
    wait_drain();
  endtask

  initial begin
    logic        order[$];
    int unsigned grants, n, both, t;
    logic [31:0] addr_before;

    rst_b = 1'b0; mem_load = 1'b1;
    if_req_valid = 1'b0; if_addr = '0;
    d_req_valid = 1'b0; d_we = 1'b0; d_funct3 = '0; d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    mem_load = 1'b0;
    chk_zero("reset");

    // Both requesters valid from reset: data, fetch, data, fetch.
    if_addr = 32'h10; d_addr = 32'h40; d_funct3 = F3_W; d_we = 1'b0;
    if_req_valid = 1'b1; d_req_valid = 1'b1;
    @(negedge clk);
    rst_b = 1'b1;
    grants = 0; n = 0; both = 0;
    forever begin
      exp_t e;
      #1;
      if (d_req_ready && if_req_ready) both++;
      if (d_req_ready) begin
        e.is_fetch = 1'b0; e.rdata = 32'h22117F80; e.err = 1'b0; e.cyc = cyc + 3;
        sb.push_back(e); order.push_back(1'b0); grants++;
      end
      if (if_req_ready) begin
        e.is_fetch = 1'b1; e.rdata = init_word(32'h10); e.err = 1'b0; e.cyc = cyc + 3;
        sb.push_back(e); order.push_back(1'b1); grants++;
      end
      if (grants >= 4 || n >= 40) break;
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0; d_req_valid = 1'b0;
    chk("both_ready", both, 32'd0);
    chk("grant_count", 32'(order.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("grant%0d", i), (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i % 2));
    wait_drain();

    fetch_req(32'h20);

    // Loads with sign/zero extension.
    data_req(1'b0, F3_B, 32'h40, 32'h0, 32'hFFFF_FF80, 1'b0, 3, 1'b1, t);
    chk("lb_mem_addr", mem_addr, 32'h40);
    wait_drain();
    load(F3_BU, 32'h40, 32'h0000_0080);
    load(F3_H,  32'h40, 32'h0000_7F80);
    load(F3_W,  32'h40, 32'h2211_7F80);
    load(F3_H,  32'h44, 32'hFFFF_9634);
    load(F3_HU, 32'h44, 32'h0000_9634);

    // SB read-modify-write.
    we_log.delete();
    data_req(1'b1, F3_B, 32'h40, 32'hAABB_CCDD, 32'h0, 1'b0, 4, 1'b1, t);
    wait_drain();
    chk("sb_we_count", 32'(we_log.size()), 32'd1);
    chk("sb_we_cycle", (we_log.size() != 0) ? we_log[0] : 32'hFFFF_FFFF, t + 3);
    chk("sb_mem_word", mem_word(32'h40), 32'h2211_7FDD);
    load(F3_W, 32'h40, 32'h2211_7FDD);

    // SW direct write.
    we_log.delete();
    data_req(1'b1, F3_W, 32'h50, 32'hDEAD_BEEF, 32'h0, 1'b0, 2, 1'b1, t);
    wait_drain();
    chk("sw_we_count", 32'(we_log.size()), 32'd1);
    chk("sw_we_cycle", (we_log.size() != 0) ? we_log[0] : 32'hFFFF_FFFF, t + 1);
    load(F3_W, 32'h50, 32'hDEAD_BEEF);

    // SH keeps the upper two lanes.
    we_log.delete();
    data_req(1'b1, F3_H, 32'h44, 32'h1234_ABCD, 32'h0, 1'b0, 4, 1'b1, t);
    wait_drain();
    chk("sh_we_count", 32'(we_log.size()), 32'd1);
    load(F3_W, 32'h44, {init_byte(32'h47), init_byte(32'h46), 16'hABCD});

    // Illegal funct3: no memory activity, error response at T+2.
    we_log.delete();
    addr_before = mem_addr;
    data_req(1'b0, 3'd3, 32'h60, 32'h0, 32'h0, 1'b1, 2, 1'b1, t);
    chk("ill_ld_addr", mem_addr, addr_before);
    wait_drain();
    data_req(1'b1, 3'd5, 32'h64, 32'hFFFF_FFFF, 32'h0, 1'b1, 2, 1'b1, t);
    chk("ill_st_addr", mem_addr, addr_before);
    wait_drain();
    chk("ill_we_count", 32'(we_log.size()), 32'd0);

    // Reset during SH RD_DATA: dropped, no write, no response.
    data_req(1'b1, F3_H, 32'h48, 32'h5555_AAAA, 32'h0, 1'b0, 4, 1'b0, t);
    @(posedge clk); #2;
    rst_b = 1'b0;
    #1;
    chk_zero("rst_sh");
    we_log.delete();
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_sh_we", 32'(we_log.size()), 32'd0);
    chk("rst_sh_word", mem_word(32'h48), init_word(32'h48));
    load(F3_W, 32'h48, init_word(32'h48));

    // Reset while the SW strobe is high aborts the write.
    data_req(1'b1, F3_W, 32'h58, 32'h1234_5678, 32'h0, 1'b0, 2, 1'b0, t);
    chk("rst_sw_we_pre", 32'(mem_write_en), 32'd1);
    #2;
    rst_b = 1'b0;
    #1;
    chk("rst_sw_we_post", 32'(mem_write_en), 32'd0);
    repeat (2) @(negedge clk);
    rst_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sw_word", mem_word(32'h58), init_word(32'h58));
    load(F3_W, 32'h58, init_word(32'h58));

    repeat (4) @(negedge clk);
    chk("final_queue", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle memory access controller that shares the single byte-lane data memory between the instruction-fetch path and the load/store path of the core. It arbitrates the two requesters round-robin, sequences reads, word writes and read-modify-write sub-word stores, and performs RISC-V load sign/zero extension by funct3. It sits between the fetch stage / execute stage and the memory model. All memory-side outputs are registered.

## Interface
- ADDR_W, 32, byte-address width of all address ports
- FETCH_FIRST, 0, requester granted on a tie when no grant has yet occurred since reset (1 = fetch, 0 = data)

- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request
- if_req_ready  out  1  fetch request accepted this cycle
- if_addr  in  ADDR_W  fetch byte address
- if_resp_valid  out  1  one-cycle pulse, if_rdata valid
- if_rdata  out  32  fetched word
- d_req_valid  in  1  data request
- d_req_ready  out  1  data request accepted this cycle
- d_we  in  1  1 = store, 0 = load
- d_funct3  in  3  RISC-V load/store funct3
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  store data (low bytes used for SB/SH)
- d_resp_valid  out  1  one-cycle pulse, load data or store completion
- d_rdata  out  32  extended load data (0 for stores)
- d_err  out  1  qualified by d_resp_valid; illegal funct3
- mem_addr  out  ADDR_W  memory byte address
- mem_write_en  out  1  write strobe
- mem_data_in  out  8 x [0:3]  write bytes, lane k = address mem_addr+k
- mem_data_out  in  8 x [0:3]  read bytes, lane k = address mem_addr+k

## Operation
- Memory contract: synchronous read, mem_data_out valid the cycle after mem_addr is presented; write commits at the clock edge ending a cycle with mem_write_en=1.
- States: IDLE, RD_ADDR, RD_DATA, WR, ERR.
- Requests accepted only in IDLE; ready = valid AND grant AND state==IDLE (combinational). Requester holds valid and payload stable until ready.
- Arbitration in IDLE: one valid wins; both valid -> requester not granted last; last_grant updated on every accept.
- Fetch: always word read. Loads: funct3 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU; byte lanes 0..1 sign- or zero-extended.
- Stores: funct3 2 SW writes all lanes directly; 0 SB / 1 SH read the word first, replace lane 0 (SB) or lanes 0-1 (SH) with d_wdata, write back unchanged upper lanes.
- Illegal funct3 (load 3,6,7; store 3-7): no memory access, ERR state, d_resp_valid with d_err=1, d_rdata=0.
- Reset values: all outputs 0, state IDLE, last_grant per FETCH_FIRST. Reset mid-operation drops the transaction, no response is ever issued; a write in flight at reset assertion is aborted (mem_write_en forced 0 asynchronously).

## Timing
- Accept at cycle T (ready high).
- Fetch/load: T+1 RD_ADDR, mem_addr valid; T+2 RD_DATA, data captured and extended; T+3 resp_valid=1, state IDLE, new accept allowed same cycle.
- SW: T+1 WR, mem_write_en=1; T+2 d_resp_valid=1, IDLE.
- SB/SH: T+1 RD_ADDR; T+2 RD_DATA merge; T+3 WR; T+4 d_resp_valid=1.
- Illegal: T+1 ERR; T+2 d_resp_valid=1, d_err=1.
- mem_write_en high exactly one cycle per store; mem_addr held stable for the whole transaction.
- No back-pressure on responses; only one transaction outstanding.

## Structure
- Shared package mem_ctrl_pkg: state enum, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), byte-lane array typedef.
- One combinational sub-module mem_load_ext: funct3 + 4 byte lanes -> 32-bit extended value; reused by the core writeback path.

## Test plan
- Memory [0x40..0x43]=0x80,0x7F,0x11,0x22; LB 0x40 -> d_rdata 0xFFFFFF80 at T+3; LBU -> 0x00000080; LH -> 0x00007F80; LW -> 0x22117F80.
- SB 0x40 wdata 0xAABBCCDD over word 0x22117F80 -> single write at T+3, word becomes 0x22117FDD, d_resp_valid at T+4.
- SW 0x50 wdata 0xDEADBEEF -> mem_write_en only at T+1, read back 0xDEADBEEF.
- Fetch and data valid every cycle from reset, FETCH_FIRST=0 -> grants data, fetch, data, fetch; neither starves.
- d_funct3=3 load -> no mem_addr change, no write, d_err=1 with d_resp_valid at T+2.
- rst_b low during SH RD_DATA -> all outputs 0 immediately, no write after release, no response; next request completes normally.
